qsfp_i2c_slave: RTL and testbench
=================================

# qsfp_i2c_slave

I2C target (responder) that emulates a QSFP management interface. It sits on the board side of the QSFP I2C buses, opposite the i2c_master_top controllers, and gives simulation and loopback a device that answers them. It decodes START/STOP, matches a 7-bit device address, and keeps an 8-bit register pointer. Register bytes are read and written through a simple single-cycle register port.

## Interface
- SLAVE_ADDR, 7'h50, 7-bit device address this target answers to.
- FILTER_LEN, 3, consecutive equal samples needed before a filtered SCL/SDA level changes (1..8).

- wb_clk_i  input  1  system clock; the only clock.
- wb_rst_i  input  1  reset, synchronous, active-high.
- scl_pad_i  input  1  raw SCL from the pad.
- sda_pad_i  input  1  raw SDA from the pad.
- sda_pad_o  output  1  constant 0 (open-drain low level).
- sda_padoen_o  output  1  1 = release SDA, 0 = drive low.
- reg_adr_o  output  8  register pointer.
- reg_dat_o  output  8  write data, valid while reg_we_o is 1.
- reg_we_o  output  1  one-cycle write strobe.
- reg_re_o  output  1  one-cycle read request; reg_dat_i is sampled on the following cycle.
- reg_dat_i  input  8  read data.
- busy_o  output  1  1 from an address match until STOP or NACK.

## Operation
- **Input path:** two-flop synchronizer, then the FILTER_LEN majority-free filter. The filtered level changes only after FILTER_LEN identical consecutive samples. Rise/fall edge pulses are derived from the filtered SCL/SDA.
- **START:** filtered SDA falls while filtered SCL is 1. It is accepted in any state, which covers repeated START. Effects: go to ADDR, bit counter = 0, release SDA. The pointer is kept.
- **STOP:** filtered SDA rises while SCL is 1. Go to IDLE, release SDA, busy_o = 0.
- **Bit sampling:** on the SCL rising edge, MSB first, with a 3-bit counter.
- **States:**
  - IDLE: wait for START.
  - ADDR: shift 8 bits. At the SCL fall after bit 8:
    - If bits[7:1] == SLAVE_ADDR, drive ACK and go to ADDR_ACK with busy_o = 1.
    - Otherwise go to IDLE with SDA released.
  - ADDR_ACK: hold ACK until the next SCL fall, then release.
    - R/W = 0: go to WR_PTR.
    - R/W = 1: go to RD_DATA, assert reg_re_o, and load the shifter from reg_dat_i on the next cycle.
  - WR_PTR: receive 8 bits. Pointer = byte. ACK via WR_ACK.
  - WR_DATA: receive 8 bits. reg_we_o pulses with reg_adr_o = pointer and reg_dat_o = byte. Pointer increments the cycle after. ACK via WR_ACK. Further bytes stay in WR_DATA.
  - WR_ACK: drive low for exactly one SCL clock (fall to fall), then go to WR_DATA.
  - RD_DATA: on each SCL fall, present the next shifter bit (sda_padoen_o = bit). After the 8th bit's SCL fall, release SDA, increment the pointer, and go to RD_ACK.
  - RD_ACK: sample master SDA on the SCL rise.
    - 0 (ACK): at the SCL fall, pulse reg_re_o, reload the shifter, drive bit 7, and stay in RD_DATA.
    - 1 (NACK): release, busy_o = 0, go to IDLE.
- **Pointer:** 8-bit, wraps 8'hFF -> 8'h00. A write of only the pointer byte followed by repeated START and a read is the standard random read.
- **ACK/NACK policy:** the target never NACKs a write byte and never stretches SCL.

## Timing
- **Reset values:** sda_padoen_o = 1, sda_pad_o = 0, reg_we_o = 0, reg_re_o = 0, reg_adr_o = 0, reg_dat_o = 0, busy_o = 0, state IDLE, filters preset to 1 (bus idle).
- **Reset mid-transfer:** SDA is released the cycle after reset asserts. The next transfer needs a fresh START.
- **Detection latency:** 2 + FILTER_LEN cycles from a pad edge to the internal edge pulse.
- **SDA drive timing:** SDA changes 1 cycle after the detected SCL fall. Output hold at the pad is therefore ≥ 3 + FILTER_LEN cycles after the true fall.
- **Clocking requirement:** SCL high and low phases each ≥ FILTER_LEN + 6 cycles. Example: 100 MHz supports 400 kHz.
- **reg_we_o:** fires 1 cycle after the 8th data-bit rising edge is detected. It is a single pulse per byte.
- **reg_re_o:** fires 1 cycle after the relevant SCL fall is detected. The first data bit is driven 2 cycles after reg_re_o.
- **START/STOP during our drive:** our own SDA changes happen only while SCL is low, so they never alias START/STOP.
- **START/STOP mid-byte:** a START or STOP in the middle of a byte aborts it. No write strobe is issued for a partial byte.

## Test plan
- **Address match, write:** START, 0xA0, ptr 0x10, data 0x5A, 0xC3, STOP -> ACK on all 4 bytes. reg_we_o pulses twice, with (0x10, 0x5A) then (0x11, 0xC3). busy_o falls at STOP.
- **Address mismatch:** START, 0xA2, then 8 more clocks -> SDA never driven low, no strobes, busy_o stays 0.
- **Random read with repeated START:** write ptr 0xFE, Sr, 0xA1, read 3 bytes with ACK, ACK, NACK. Register model returns adr ^ 0xFF. Required data on the bus: 0x01, 0x00, 0xFF. Pointer wraps to 0x01. SDA is released after the NACK.
- **Glitch rejection:** FILTER_LEN = 3. A 2-cycle low glitch on SCL while high is ignored, with no bit sampled. A 2-cycle SDA pulse while SCL is high produces no START or STOP.
- **Reset and abort:** assert wb_rst_i while the target drives ACK -> sda_padoen_o = 1 next cycle. A STOP injected after 4 data bits produces no reg_we_o. A following full transfer works normally.

Source files
------------

// File: rtl/qsfp_i2c_slave_if.sv
// Pad and register-port bundle between the QSFP I2C target and its environment.
// The slave modport is the target's view; master is the board/bench view.
interface qsfp_i2c_slave_if;
    logic       scl_pad_i;
    logic       sda_pad_i;
    logic       sda_pad_o;
    logic       sda_padoen_o;
    logic [7:0] reg_adr_o;
    logic [7:0] reg_dat_o;
    logic       reg_we_o;
    logic       reg_re_o;
    logic [7:0] reg_dat_i;
    logic       busy_o;

    modport slave (
        input  scl_pad_i, sda_pad_i, reg_dat_i,
        output sda_pad_o, sda_padoen_o, reg_adr_o, reg_dat_o, reg_we_o, reg_re_o, busy_o
    );

    modport master (
        output scl_pad_i, sda_pad_i, reg_dat_i,
        input  sda_pad_o, sda_padoen_o, reg_adr_o, reg_dat_o, reg_we_o, reg_re_o, busy_o
    );
endinterface

// File: rtl/qsfp_i2c_slave.sv
// I2C target emulating a QSFP management device: filtered SCL/SDA, START/STOP
// decode, 7-bit address match, auto-incrementing register pointer.
module qsfp_i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         FILTER_LEN = 3
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    qsfp_i2c_slave_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_PTR, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK
    } state_t;

    state_t          state_q, state_nxt;

    // Index 1 = SCL, index 0 = SDA.
    logic [1:0]      raw, sync1, sync2, filt, filt_d;
    logic [1:0][3:0] fcnt;

    logic [7:0] shifter, ptr, dat_q, rx_byte;
    logic [2:0] bit_cnt;
    logic       got8, ack_bit;
    logic       sda_oe_q, we_q, re_q, re_d, busy_q;
    logic       sda_oe_nxt, we_nxt, re_nxt, busy_nxt;
    logic       scl_rise, scl_fall, sda_rise, sda_fall, start, stop;
    logic       addr_hit, rx_state;

    assign raw = {bus.scl_pad_i, bus.sda_pad_i};

    // A filtered level only moves after FILTER_LEN identical samples that differ from it.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1  <= '1;
            sync2  <= '1;
            filt   <= '1;
            filt_d <= '1;
            fcnt   <= '0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            filt_d <= filt;
            for (int g = 0; g < 2; g++) begin
                if (sync2[g] == filt[g]) begin
                    fcnt[g] <= '0;
                end else if (fcnt[g] == 4'(FILTER_LEN - 1)) begin
                    filt[g] <= sync2[g];
                    fcnt[g] <= '0;
                end else begin
                    fcnt[g] <= fcnt[g] + 4'd1;
                end
            end
        end
    end

    assign scl_rise = filt[1] & ~filt_d[1];
    assign scl_fall = ~filt[1] & filt_d[1];
    assign sda_rise = filt[0] & ~filt_d[0];
    assign sda_fall = ~filt[0] & filt_d[0];
    assign start    = sda_fall & filt[1];
    assign stop     = sda_rise & filt[1];
    assign addr_hit = (shifter[7:1] == SLAVE_ADDR);
    assign rx_state = (state_q == S_ADDR) || (state_q == S_WR_PTR) || (state_q == S_WR_DATA);
    assign rx_byte  = {shifter[6:0], filt[0]};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= S_IDLE;
        else          state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        if (start) begin
            state_nxt = S_ADDR;
        end else if (stop) begin
            state_nxt = S_IDLE;
        end else if (scl_fall) begin
            case (state_q)
                S_ADDR:              if (got8) state_nxt = addr_hit ? S_ADDR_ACK : S_IDLE;
                S_ADDR_ACK:          state_nxt = shifter[0] ? S_RD_DATA : S_WR_PTR;
                S_WR_PTR, S_WR_DATA: if (got8) state_nxt = S_WR_ACK;
                S_WR_ACK:            state_nxt = S_WR_DATA;
                S_RD_DATA:           if (bit_cnt == 3'd7) state_nxt = S_RD_ACK;
                S_RD_ACK:            state_nxt = ack_bit ? S_IDLE : S_RD_DATA;
                default:             state_nxt = state_q;
            endcase
        end
    end

    // Next values of the registered outputs; all SDA changes follow a detected SCL fall.
    always_comb begin
        sda_oe_nxt = sda_oe_q;
        we_nxt     = 1'b0;
        re_nxt     = 1'b0;
        busy_nxt   = busy_q;
        if (start) begin
            sda_oe_nxt = 1'b1;
        end else if (stop) begin
            sda_oe_nxt = 1'b1;
            busy_nxt   = 1'b0;
        end else if (re_d) begin
            sda_oe_nxt = bus.reg_dat_i[7];
        end else if (scl_rise) begin
            we_nxt = (state_q == S_WR_DATA) && (bit_cnt == 3'd7);
        end else if (scl_fall) begin
            case (state_q)
                S_ADDR: if (got8) begin
                    sda_oe_nxt = ~addr_hit;
                    busy_nxt   = addr_hit;
                end
                S_ADDR_ACK: begin
                    sda_oe_nxt = 1'b1;
                    re_nxt     = shifter[0];
                end
                S_WR_PTR, S_WR_DATA: if (got8) sda_oe_nxt = 1'b0;
                S_WR_ACK:  sda_oe_nxt = 1'b1;
                S_RD_DATA: sda_oe_nxt = (bit_cnt == 3'd7) ? 1'b1 : shifter[6];
                S_RD_ACK: begin
                    sda_oe_nxt = 1'b1;
                    re_nxt     = ~ack_bit;
                    busy_nxt   = ~ack_bit;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sda_oe_q <= 1'b1;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            re_d     <= 1'b0;
            busy_q   <= 1'b0;
            shifter  <= '0;
            bit_cnt  <= '0;
            got8     <= 1'b0;
            ack_bit  <= 1'b1;
            ptr      <= '0;
            dat_q    <= '0;
        end else begin
            sda_oe_q <= sda_oe_nxt;
            we_q     <= we_nxt;
            re_q     <= re_nxt;
            re_d     <= re_q;
            busy_q   <= busy_nxt;
            if (we_q) ptr <= ptr + 8'd1;
            // START/STOP discards any partial byte, so no strobe can follow.
            if (start || stop) begin
                bit_cnt <= '0;
                got8    <= 1'b0;
            end else if (re_d) begin
                shifter <= bus.reg_dat_i;
                bit_cnt <= '0;
            end else if (scl_rise) begin
                if (rx_state) begin
                    shifter <= rx_byte;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        got8 <= 1'b1;
                        if (state_q == S_WR_PTR)  ptr   <= rx_byte;
                        if (state_q == S_WR_DATA) dat_q <= rx_byte;
                    end
                end
                if (state_q == S_RD_ACK) ack_bit <= filt[0];
            end else if (scl_fall) begin
                if (rx_state && got8) begin
                    got8    <= 1'b0;
                    bit_cnt <= '0;
                end
                if (state_q == S_RD_DATA) begin
                    shifter <= {shifter[6:0], 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) ptr <= ptr + 8'd1;
                end
                if (state_q == S_ADDR_ACK || state_q == S_WR_ACK || state_q == S_RD_ACK)
                    bit_cnt <= '0;
            end
        end
    end

    assign bus.sda_pad_o    = 1'b0;
    assign bus.sda_padoen_o = sda_oe_q;
    assign bus.reg_adr_o    = ptr;
    assign bus.reg_dat_o    = dat_q;
    assign bus.reg_we_o     = we_q;
    assign bus.reg_re_o     = re_q;
    assign bus.busy_o       = busy_q;
endmodule

// File: tb/tb_qsfp_i2c_slave.sv
// Bench for qsfp_i2c_slave: bit-banged I2C master, register file on the register
// port, and a byte-level memory model of what the master wrote.
`timescale 1ns/1ps
module tb_qsfp_i2c_slave;
    localparam int Q = 6;
    localparam int H = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qsfp_i2c_slave_if bus();

    logic m_scl = 1'b1, m_sda = 1'b1, scl_gl = 1'b0, sda_gl = 1'b0;
    logic [7:0]  regfile [256];
    logic [7:0]  model   [256];
    logic [15:0] wr_log [$];
    int re_cnt = 0, low_cnt = 0;
    int checks = 0, failures = 0;

    assign bus.scl_pad_i = m_scl & ~scl_gl;
    assign bus.sda_pad_i = (m_sda ^ sda_gl) & bus.sda_padoen_o;
    assign bus.reg_dat_i = regfile[bus.reg_adr_o];

    qsfp_i2c_slave #(.SLAVE_ADDR(7'h50), .FILTER_LEN(3)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    // Register-port device: contents start as adr ^ 0xFF and take DUT write strobes.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) regfile[i] <= 8'(i) ^ 8'hFF;
        end else begin
            if (bus.reg_we_o) begin
                wr_log.push_back({bus.reg_adr_o, bus.reg_dat_o});
                regfile[bus.reg_adr_o] <= bus.reg_dat_o;
            end
            if (bus.reg_re_o) re_cnt++;
            if (!bus.sda_padoen_o) low_cnt++;
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic init_model();
        for (int i = 0; i < 256; i++) model[i] = 8'(i) ^ 8'hFF;
    endtask

    task automatic send_bit(input logic b, input logic gl);
        m_sda = b;
        wait_clk(Q);
        m_scl = 1'b1;
        if (gl) begin
            wait_clk(6); scl_gl = 1'b1; wait_clk(2); scl_gl = 1'b0;
            wait_clk(2); sda_gl = 1'b1; wait_clk(2); sda_gl = 1'b0; wait_clk(4);
        end else begin
            wait_clk(H);
        end
        m_scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1;
        wait_clk(Q);
        m_scl = 1'b1;
        wait_clk(H / 2);
        b = bus.sda_pad_i;
        wait_clk(H / 2);
        m_scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(H);
        m_sda = 1'b0; wait_clk(H);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b1; wait_clk(H);
        m_sda = 1'b1; wait_clk(H);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic gl, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i], gl);
        recv_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic nack);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(v);
            d[i] = v;
        end
        send_bit(nack, 1'b0);
    endtask

    task automatic do_write(input logic [7:0] ptr, input logic [3:0][7:0] d, input int n, input logic gl);
        logic a;
        logic [15:0] exp;
        wr_log.delete();
        i2c_start();
        send_byte(8'hA0, 1'b0, a);
        checks++; if (a !== 1'b0) begin failures++; $display("FAIL wr_addr_ack got=%b exp=0", a); end
        send_byte(ptr, gl, a);
        checks++; if (a !== 1'b0) begin failures++; $display("FAIL wr_ptr_ack got=%b exp=0", a); end
        for (int i = 0; i < n; i++) begin
            send_byte(d[i], gl, a);
            checks++; if (a !== 1'b0) begin failures++; $display("FAIL wr_data_ack byte=%0d got=%b exp=0", i, a); end
            model[8'(ptr + 8'(i))] = d[i];
        end
        checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL wr_busy_mid got=%b exp=1", bus.busy_o); end
        i2c_stop();
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL wr_busy_stop got=%b exp=0", bus.busy_o); end
        checks++; if (wr_log.size() !== n) begin failures++; $display("FAIL wr_strobe_count got=%0d exp=%0d", wr_log.size(), n); end
        for (int i = 0; i < n && i < wr_log.size(); i++) begin
            exp = {8'(ptr + 8'(i)), d[i]};
            checks++;
            if (wr_log[i] !== exp) begin
                failures++; $display("FAIL wr_strobe byte=%0d got=%h exp=%h", i, wr_log[i], exp);
            end
        end
    endtask

    task automatic do_read(input logic [7:0] ptr, input int n);
        logic a;
        logic [7:0] b, exp;
        int re0;
        i2c_start();
        send_byte(8'hA0, 1'b0, a);
        checks++; if (a !== 1'b0) begin failures++; $display("FAIL rd_addr_ack got=%b exp=0", a); end
        send_byte(ptr, 1'b0, a);
        checks++; if (a !== 1'b0) begin failures++; $display("FAIL rd_ptr_ack got=%b exp=0", a); end
        re0 = re_cnt;
        i2c_start();
        send_byte(8'hA1, 1'b0, a);
        checks++; if (a !== 1'b0) begin failures++; $display("FAIL rd_addr2_ack got=%b exp=0", a); end
        for (int i = 0; i < n; i++) begin
            recv_byte(b, logic'(i == n - 1));
            exp = model[8'(ptr + 8'(i))];
            checks++; if (b !== exp) begin failures++; $display("FAIL rd_data byte=%0d got=%h exp=%h", i, b, exp); end
        end
        wait_clk(2);
        checks++; if (bus.sda_padoen_o !== 1'b1) begin failures++; $display("FAIL rd_release got=%b exp=1", bus.sda_padoen_o); end
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL rd_busy_nack got=%b exp=0", bus.busy_o); end
        checks++; if (bus.reg_adr_o !== 8'(ptr + 8'(n))) begin failures++; $display("FAIL rd_ptr_final got=%h exp=%h", bus.reg_adr_o, 8'(ptr + 8'(n))); end
        checks++; if (re_cnt - re0 !== n) begin failures++; $display("FAIL rd_re_count got=%0d exp=%0d", re_cnt - re0, n); end
        i2c_stop();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clk(4);
        checks++; if (bus.sda_padoen_o !== 1'b1) begin failures++; $display("FAIL rst_padoen got=%b exp=1", bus.sda_padoen_o); end
        checks++; if (bus.sda_pad_o !== 1'b0)    begin failures++; $display("FAIL rst_pad_o got=%b exp=0", bus.sda_pad_o); end
        checks++; if (bus.reg_we_o !== 1'b0)     begin failures++; $display("FAIL rst_we got=%b exp=0", bus.reg_we_o); end
        checks++; if (bus.reg_re_o !== 1'b0)     begin failures++; $display("FAIL rst_re got=%b exp=0", bus.reg_re_o); end
        checks++; if (bus.reg_adr_o !== 8'h00)   begin failures++; $display("FAIL rst_adr got=%h exp=00", bus.reg_adr_o); end
        checks++; if (bus.reg_dat_o !== 8'h00)   begin failures++; $display("FAIL rst_dat got=%h exp=00", bus.reg_dat_o); end
        checks++; if (bus.busy_o !== 1'b0)       begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy_o); end
        rst = 1'b0;
        init_model();
        wait_clk(20);
        checks++; if (bus.sda_padoen_o !== 1'b1) begin failures++; $display("FAIL idle_padoen got=%b exp=1", bus.sda_padoen_o); end
    endtask

    task automatic test_write();
        do_write(8'h10, {16'h0, 8'hC3, 8'h5A}, 2, 1'b0);
    endtask

    task automatic test_mismatch();
        logic [7:0] ab;
        logic [6:0] a7;
        logic a;
        int low0, re0;
        for (int k = 0; k < 3; k++) begin
            if (k == 0) ab = 8'hA2;
            else begin
                do a7 = 7'($urandom); while (a7 == 7'h50);
                ab = {a7, 1'($urandom)};
            end
            wr_log.delete();
            low0 = low_cnt;
            re0  = re_cnt;
            i2c_start();
            send_byte(ab, 1'b0, a);
            checks++; if (a !== 1'b1) begin failures++; $display("FAIL mm_addr_nack adr=%h got=%b exp=1", ab, a); end
            send_byte(8'($urandom), 1'b0, a);
            checks++; if (a !== 1'b1) begin failures++; $display("FAIL mm_data_nack adr=%h got=%b exp=1", ab, a); end
            checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL mm_busy adr=%h got=%b exp=0", ab, bus.busy_o); end
            i2c_stop();
            checks++; if (low_cnt !== low0) begin failures++; $display("FAIL mm_sda_driven adr=%h got=%0d exp=%0d", ab, low_cnt, low0); end
            checks++; if (wr_log.size() != 0 || re_cnt != re0) begin
                failures++; $display("FAIL mm_strobes adr=%h got=%0d/%0d exp=0/0", ab, wr_log.size(), re_cnt - re0);
            end
        end
    endtask

    task automatic test_random_read();
        do_read(8'hFE, 3);
    endtask

    task automatic test_glitch();
        logic [3:0][7:0] d;
        for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
        do_write(8'($urandom_range(32, 200)), d, 2, 1'b1);
    endtask

    task automatic test_reset_abort();
        logic a;
        logic [3:0][7:0] d;
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(logic'((8'hA0 >> i) & 8'h01), 1'b0);
        for (int i = 0; i < 20 && bus.sda_padoen_o; i++) wait_clk(1);
        checks++; if (bus.sda_padoen_o !== 1'b0) begin failures++; $display("FAIL ab_ack_drive got=%b exp=0", bus.sda_padoen_o); end
        rst = 1'b1;
        wait_clk(1);
        checks++; if (bus.sda_padoen_o !== 1'b1) begin failures++; $display("FAIL ab_rst_release got=%b exp=1", bus.sda_padoen_o); end
        wait_clk(1);
        rst = 1'b0;
        init_model();
        i2c_stop();
        wr_log.delete();
        i2c_start();
        send_byte(8'hA0, 1'b0, a);
        checks++; if (a !== 1'b0) begin failures++; $display("FAIL ab_addr_ack got=%b exp=0", a); end
        send_byte(8'h33, 1'b0, a);
        checks++; if (a !== 1'b0) begin failures++; $display("FAIL ab_ptr_ack got=%b exp=0", a); end
        for (int i = 0; i < 4; i++) send_bit(1'($urandom), 1'b0);
        i2c_stop();
        checks++; if (wr_log.size() != 0) begin failures++; $display("FAIL ab_no_strobe got=%0d exp=0", wr_log.size()); end
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL ab_busy got=%b exp=0", bus.busy_o); end
        for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
        do_write(8'h33, d, 3, 1'b0);
        do_read(8'h33, 3);
    endtask

    task automatic test_back_to_back();
        logic [3:0][7:0] d;
        logic [7:0] p;
        int n;
        for (int k = 0; k < 4; k++) begin
            p = (k == 1) ? 8'hFF : 8'($urandom);
            n = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
            do_write(p, d, n, 1'b0);
            do_read(p, n);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_random_read();
        test_mismatch();
        test_glitch();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
